// File: rtl/cc_unit.sv
// Condition-code unit: captures ALU results, derives ZF/SF/OF, commits to the CC
// register and evaluates y86-64 jXX/cmovXX conditions. Optional macro: CC_FWD_EN.
module cc_unit #(
  parameter int         W        = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic [1:0]   alu_fun,
  input  logic         set_cc,
  input  logic         exc_kill,
  input  logic [3:0]   cond_ifun,
  output logic         cond_out,
  output logic         cond_err,
  output logic [2:0]   cc_out,
  output logic         cc_updated
);

  // state   | meaning
  // IDLE    | ready; latches an ALU result when alu_valid is high
  // CAPTURE | derives candidate flags from the latched result
  // COMMIT  | writes pending flags unless set_cc is clear or exc_kill is high
  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

  localparam logic [1:0] FUN_ADD = 2'd0;
  localparam logic [1:0] FUN_SUB = 2'd1;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q, r_q;
  logic [1:0]     fun_q;
  logic           set_q;
  logic [2:0]     pend_q;
  logic [2:0]     cand;
  logic           latch_en, cap_en, commit_en;
  logic [2:0]     cond_flags;
  logic           zf, sf, of;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (alu_valid) state_nxt = CAPTURE;
      CAPTURE: state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_ready = (state == IDLE);
    latch_en  = (state == IDLE) && alu_valid;
    cap_en    = (state == CAPTURE);
    commit_en = (state == COMMIT) && set_q && !exc_kill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      fun_q <= '0;
      set_q <= 1'b0;
    end else if (latch_en) begin
      a_q   <= alu_a;
      b_q   <= alu_b;
      r_q   <= alu_result;
      fun_q <= alu_fun;
      set_q <= set_cc;
    end
  end

  // Flags in {ZF,SF,OF} order; OF only meaningful for add/sub.
  always_comb begin
    cand[2] = (r_q == '0);
    cand[1] = r_q[W-1];
    cand[0] = 1'b0;
    if (fun_q == FUN_ADD)
      cand[0] = (a_q[W-1] == b_q[W-1]) && (r_q[W-1] != a_q[W-1]);
    else if (fun_q == FUN_SUB)
      cand[0] = (a_q[W-1] != b_q[W-1]) && (r_q[W-1] != b_q[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pend_q <= '0;
    else if (cap_en) pend_q <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_out     <= CC_RESET;
      cc_updated <= 1'b0;
    end else begin
      cc_updated <= commit_en;
      if (commit_en) cc_out <= pend_q;
    end
  end

`ifdef CC_FWD_EN
  assign cond_flags = commit_en ? pend_q : cc_out;
`else
  assign cond_flags = cc_out;
`endif

  assign zf = cond_flags[2];
  assign sf = cond_flags[1];
  assign of = cond_flags[0];

  always_comb begin
    cond_out = 1'b0;
    cond_err = 1'b0;
    case (cond_ifun)
      4'd0: cond_out = 1'b1;
      4'd1: cond_out = (sf ^ of) | zf;
      4'd2: cond_out = sf ^ of;
      4'd3: cond_out = zf;
      4'd4: cond_out = !zf;
      4'd5: cond_out = !(sf ^ of);
      4'd6: cond_out = !(sf ^ of) && !zf;
      default: cond_err = rst_n;  // error flag held low while in reset
    endcase
  end

endmodule

// File: tb/tb_cc_unit.sv
// Scoreboard bench for cc_unit: expected CC values are queued at handshake and
// popped by a monitor on every cc_updated pulse.
module tb_cc_unit;
  localparam int W = 64;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         alu_valid = 1'b0;
  logic         alu_ready;
  logic [W-1:0] alu_a = '0, alu_b = '0, alu_result = '0;
  logic [1:0]   alu_fun = '0;
  logic         set_cc = 1'b0;
  logic         exc_kill = 1'b0;
  logic [3:0]   cond_ifun = '0;
  logic         cond_out, cond_err;
  logic [2:0]   cc_out;
  logic         cc_updated;

  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  logic [2:0] model_cc;

  cc_unit #(.W(W), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_fun(alu_fun),
    .set_cc(set_cc), .exc_kill(exc_kill), .cond_ifun(cond_ifun),
    .cond_out(cond_out), .cond_err(cond_err), .cc_out(cc_out),
    .cc_updated(cc_updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every CC write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && cc_updated) begin
      if (exp_q.size() == 0) begin
        chk("cc_updated_unexpected", 64'd1, 64'd0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("cc_commit", {61'd0, cc_out}, {61'd0, e});
      end
    end
  end

  task automatic chk_cond(input logic [3:0] ifun, input logic exp_out, input logic exp_err);
    cond_ifun = ifun;
    #1;
    chk($sformatf("cond_out_ifun%0d", ifun), {63'd0, cond_out}, {63'd0, exp_out});
    chk($sformatf("cond_err_ifun%0d", ifun), {63'd0, cond_err}, {63'd0, exp_err});
  endtask

  // One transaction: kill_pre drives exc_kill in IDLE/CAPTURE, kill_com in COMMIT.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                       input logic [1:0] fun, input logic set, input logic kill_pre,
                       input logic kill_com, input logic [2:0] exp_cc);
    logic commits;
    commits = set && !kill_com;
    @(negedge clk);
    chk("ready_idle", {63'd0, alu_ready}, 64'd1);
    alu_valid = 1'b1; alu_a = a; alu_b = b; alu_result = r; alu_fun = fun;
    set_cc = set; exc_kill = kill_pre;
    if (commits) exp_q.push_back(exp_cc);
    @(negedge clk);
    alu_valid = 1'b0;
    chk("ready_capture", {63'd0, alu_ready}, 64'd0);
    @(negedge clk);
    exc_kill = kill_com;
    cond_ifun = 4'd3;
    #1;
    chk("cc_hold_in_commit", {61'd0, cc_out}, {61'd0, model_cc});
`ifdef CC_FWD_EN
    chk("cond_fwd_commit", {63'd0, cond_out}, {63'd0, commits ? exp_cc[2] : model_cc[2]});
`else
    chk("cond_nofwd_commit", {63'd0, cond_out}, {63'd0, model_cc[2]});
`endif
    @(negedge clk);
    exc_kill = 1'b0;
    #1;
    if (commits) model_cc = exp_cc;
    chk("cc_after_commit", {61'd0, cc_out}, {61'd0, model_cc});
    chk("scoreboard_drained", exp_q.size(), 64'd0);
  endtask

  logic [63:0] bb_a[3], bb_b[3], bb_r[3];
  logic [1:0]  bb_f[3];
  logic [2:0]  bb_e[3];

  initial begin
    model_cc = 3'b100;
    cond_ifun = 4'd9;
    #12;
    chk("rst_cc_out", {61'd0, cc_out}, 64'd4);
    chk("rst_ready", {63'd0, alu_ready}, 64'd1);
    chk("rst_cond_err", {63'd0, cond_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cc_out", {61'd0, cc_out}, 64'd4);
    chk("post_rst_ready", {63'd0, alu_ready}, 64'd1);
    chk("post_rst_cc_updated", {63'd0, cc_updated}, 64'd0);
    chk_cond(4'd3, 1'b1, 1'b0);

    // Idle with valid low holds state
    repeat (3) @(negedge clk);
    #1;
    chk("idle_hold_cc", {61'd0, cc_out}, 64'd4);
    chk("idle_hold_ready", {63'd0, alu_ready}, 64'd1);

    // sub 5-5=0 -> Z
    issue(64'd5, 64'd5, 64'd0, 2'd1, 1'b1, 1'b0, 1'b0, 3'b100);
    chk_cond(4'd4, 1'b0, 1'b0);

    // add overflow: max + 1
    issue(MAXP, 64'd1, MINN, 2'd0, 1'b1, 1'b0, 1'b0, 3'b011);
    chk_cond(4'd2, 1'b0, 1'b0);
    chk_cond(4'd5, 1'b1, 1'b0);
    chk_cond(4'd0, 1'b1, 1'b0);
    chk_cond(4'd1, 1'b0, 1'b0);
    chk_cond(4'd6, 1'b1, 1'b0);
    chk_cond(4'd3, 1'b0, 1'b0);
    chk_cond(4'd9, 1'b0, 1'b1);
    chk_cond(4'd15, 1'b0, 1'b1);

    // killed in COMMIT, then set_cc=0: no commit either time
    issue(64'd1, 64'd0, ONES, 2'd1, 1'b1, 1'b0, 1'b1, 3'b010);
    issue(64'd1, 64'd0, ONES, 2'd1, 1'b0, 1'b0, 1'b0, 3'b010);

    // same sub, kill only in IDLE/CAPTURE is ignored -> S
    issue(64'd1, 64'd0, ONES, 2'd1, 1'b1, 1'b1, 1'b0, 3'b010);
    chk_cond(4'd2, 1'b1, 1'b0);
    chk_cond(4'd1, 1'b1, 1'b0);
    chk_cond(4'd4, 1'b1, 1'b0);

    // sub overflow: b=min, a=1 -> 0x7FF..F
    issue(64'd1, MINN, MAXP, 2'd1, 1'b1, 1'b0, 1'b0, 3'b001);
    chk_cond(4'd2, 1'b1, 1'b0);
    chk_cond(4'd6, 1'b0, 1'b0);

    // and with sign bits that would trip the add rule: OF stays 0
    issue(MINN, MINN, 64'd0, 2'd2, 1'b1, 1'b0, 1'b0, 3'b100);
    issue(64'd0, ONES, ONES, 2'd3, 1'b1, 1'b0, 1'b0, 3'b010);

    // Back-to-back with alu_valid held high
    bb_a[0] = ONES; bb_b[0] = 64'd0; bb_r[0] = ONES; bb_f[0] = 2'd3; bb_e[0] = 3'b010;
    bb_a[1] = MAXP; bb_b[1] = 64'd1; bb_r[1] = MINN; bb_f[1] = 2'd0; bb_e[1] = 3'b011;
    bb_a[2] = 64'd1; bb_b[2] = MINN; bb_r[2] = MAXP; bb_f[2] = 2'd1; bb_e[2] = 3'b001;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_%0d", i), {63'd0, alu_ready}, {63'd0, (i % 3) == 0});
      if ((i % 3) == 0) begin
        alu_valid = 1'b1; set_cc = 1'b1;
        alu_a = bb_a[i/3]; alu_b = bb_b[i/3]; alu_result = bb_r[i/3]; alu_fun = bb_f[i/3];
        exp_q.push_back(bb_e[i/3]);
      end
    end
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    model_cc = 3'b001;
    chk("b2b_cc_out", {61'd0, cc_out}, 64'd1);
    chk("b2b_drained", exp_q.size(), 64'd0);

    // Reset pulsed during CAPTURE discards the pending add
    @(negedge clk);
    alu_valid = 1'b1; set_cc = 1'b1; alu_fun = 2'd0;
    alu_a = MAXP; alu_b = 64'd1; alu_result = MINN;
    @(negedge clk);
    alu_valid = 1'b0;
    rst_n = 1'b0;
    cond_ifun = 4'd9;
    #1;
    chk("midrst_cc_out", {61'd0, cc_out}, 64'd4);
    chk("midrst_ready", {63'd0, alu_ready}, 64'd1);
    chk("midrst_cond_err", {63'd0, cond_err}, 64'd0);
    chk_cond(4'd3, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cc = 3'b100;
    repeat (4) @(negedge clk);
    #1;
    chk("postrst_cc_out", {61'd0, cc_out}, 64'd4);
    chk("postrst_ready", {63'd0, alu_ready}, 64'd1);
    chk("final_drained", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cc_unit.md
Name: cc_unit

Overview:
- Condition-code unit on the consumer side of the 64-bit ALU result interface.
- Accepts ALU operands, result and function code through a valid/ready handshake.
- Derives ZF/SF/OF and commits them to the CC register. Downstream exceptions can suppress the commit.
- Evaluates y86-64 jXX/cmovXX conditions from the committed flags for the execute stage.

Parameters:
- W, 64, datapath width; sign bit is bit W-1.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU presents a result to commit.
- alu_ready  out  1  unit can accept a result.
- alu_a  in  W  operand A (valA / aluA).
- alu_b  in  W  operand B (valB / aluB).
- alu_result  in  W  ALU output valE.
- alu_fun  in  2  0=add, 1=sub (valE=B-A), 2=and, 3=xor.
- set_cc  in  1  instruction updates CC (OPq); sampled with alu_valid.
- exc_kill  in  1  exception in M/W stage; sampled in COMMIT.
- cond_ifun  in  4  condition code of the jXX/cmovXX being evaluated.
- cond_out  out  1  condition result.
- cond_err  out  1  cond_ifun illegal (>6).
- cc_out  out  3  committed {ZF,SF,OF}.
- cc_updated  out  1  one-cycle pulse when CC is written.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cc_out=CC_RESET, cc_updated=0, capture registers=0.
  - While in reset: alu_ready=1, cond_err=0; cond_out is evaluated from CC_RESET.
- FSM states IDLE, CAPTURE, COMMIT. alu_ready=1 only in IDLE.
- IDLE:
  - If alu_valid=1, latch alu_a, alu_b, alu_result, alu_fun and set_cc, then go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE: compute candidate flags from the latched values into a pending register; go to COMMIT.
- Candidate flag rules:
  - ZF = (r==0); SF = r[W-1].
  - add: OF = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
  - sub: OF = (a[W-1]!=b[W-1]) && (r[W-1]!=b[W-1]).
  - and/xor: OF = 0.
- COMMIT:
  - If latched set_cc=1 and exc_kill=0, write pending flags to cc_out at the clock edge and pulse cc_updated for exactly that cycle.
  - Otherwise cc_out is unchanged and cc_updated=0.
  - Always return to IDLE.
- Latency and throughput:
  - A handshake at edge N updates cc_out at edge N+2.
  - Maximum throughput is 1 result per 3 cycles. alu_valid may stay high across results; each IDLE cycle with valid accepts a new one.
- Condition evaluation is combinational from cc_out (zero latency):
  - ifun 0 (always) = 1.
  - ifun 1 (le) = (SF^OF)|ZF.
  - ifun 2 (l) = SF^OF.
  - ifun 3 (e) = ZF.
  - ifun 4 (ne) = !ZF.
  - ifun 5 (ge) = !(SF^OF).
  - ifun 6 (g) = !(SF^OF)&!ZF.
  - ifun 7..15: cond_out=0, cond_err=1.
- Boundary conditions:
  - exc_kill asserted in IDLE or CAPTURE is ignored; only COMMIT samples it.
  - Reset mid-operation discards any captured or pending result; cc_out returns to CC_RESET.
  - alu_valid=0 in IDLE holds all state.

Optional Feature:
- Macro: CC_FWD_EN.
- Defined:
  - During COMMIT, when set_cc=1 and exc_kill=0, cond_out/cond_err are evaluated from the pending flags instead of cc_out. This lets a dependent jXX see the new flags one cycle early.
  - cc_out timing is unchanged.
- Undefined: cond_out always reflects cc_out.

Test Plan:
- Reset check: after rst_n deassert -> cc_out=3'b100, alu_ready=1, cond_ifun=3 gives cond_out=1, cc_updated=0.
- sub, a=5, b=5, r=0, set_cc=1 -> cc_out=3'b100 two edges after handshake; cc_updated pulses once; cond_ifun=4 gives cond_out=0.
- add, a=0x7FFFFFFFFFFFFFFF, b=1, r=0x8000000000000000 -> cc_out=3'b011; cond_ifun=2 gives 0, cond_ifun=5 gives 1.
- sub, a=1, b=0, r=0xFFFFFFFFFFFFFFFF with exc_kill=1 in COMMIT -> cc_out unchanged, no cc_updated pulse. Repeat with set_cc=0 -> same result.
- alu_valid held high for 3 back-to-back results -> accepted at IDLE cycles only (every 3rd cycle); alu_ready pattern 1,0,0 repeating.
- rst_n pulsed low during CAPTURE -> cc_out=CC_RESET immediately, state IDLE, no stale commit afterwards. With CC_FWD_EN defined, cond_out shows new flags during COMMIT.
